// File: rtl/dcache_burst_adapter.sv
// Purpose : turns line-granular dcache refill/writeback requests into 4-beat 64-bit bursts.
// Latency : write resp 5 cycles after request (ready=1); read resp 1 cycle after last beat.
// Backpres: write beats and read command hold while bmem_ready=0; read beats may gap freely.
//
// Ports: dfp_* = cache-side line interface (level requests held until dfp_resp),
//        bmem_* = burst memory bus, proto_err = sticky flag for rvalid outside RD_WAIT.
module dcache_burst_adapter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             dfp_addr,
    input  logic                    dfp_read,
    input  logic                    dfp_write,
    input  logic [BEATS*BEAT_W-1:0] dfp_wdata,
    output logic [BEATS*BEAT_W-1:0] dfp_rdata,
    output logic                    dfp_resp,
    output logic [31:0]             bmem_addr,
    output logic                    bmem_read,
    output logic                    bmem_write,
    output logic [BEAT_W-1:0]       bmem_wdata,
    input  logic                    bmem_ready,
    input  logic [BEAT_W-1:0]       bmem_rdata,
    input  logic                    bmem_rvalid,
    output logic                    proto_err
);

    localparam int LINE_W = BEATS * BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Byte offset within a line; these address bits never reach the bus.
    localparam logic [31:0] LINE_MASK = ~32'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BEAT = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4,
        GUARD   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        addr_q;
    logic [LINE_W-1:0]  buf_q;
    logic [LINE_W-1:0]  rdata_q;
    logic [LINE_W-1:0]  line_fwd;
    logic               proto_err_q;

    // Buffer with the incoming read beat merged in, so the last beat can be
    // captured straight into dfp_rdata and be valid in the RESP cycle.
    always_comb begin
        line_fwd = buf_q;
        line_fwd[int'(cnt_q) * BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = 32'd0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        case (state_q)
            IDLE: begin
                // Writeback has priority so a dirty victim leaves before its refill.
                if (dfp_write)     state_d = WR_BEAT;
                else if (dfp_read) state_d = RD_REQ;
            end
            WR_BEAT: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = buf_q[int'(cnt_q) * BEAT_W +: BEAT_W];
                if (bmem_ready && cnt_q == LAST_BEAT) state_d = RESP;
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bmem_rvalid && cnt_q == LAST_BEAT) state_d = RESP;
            end
            RESP: begin
                dfp_resp = 1'b1;
                state_d  = GUARD;
            end
            // Upstream still shows the old request this cycle; ignore it.
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            addr_q      <= 32'd0;
            buf_q       <= '0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (bmem_rvalid && state_q != RD_WAIT) proto_err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (dfp_write || dfp_read) begin
                        addr_q <= dfp_addr & LINE_MASK;
                        buf_q  <= dfp_wdata;
                        cnt_q  <= '0;
                    end
                end
                WR_BEAT: begin
                    // Counter wraps to 0 on the last accepted beat.
                    if (bmem_ready) cnt_q <= cnt_q + 1'b1;
                end
                RD_WAIT: begin
                    if (bmem_rvalid) begin
                        buf_q <= line_fwd;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) rdata_q <= line_fwd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dfp_rdata = rdata_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_dcache_burst_adapter.sv
// Purpose : directed self-checking bench for dcache_burst_adapter.
// Latency : n/a (bench).
// Backpres: drives bmem_ready patterns and gapped read beats.
module tb_dcache_burst_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         proto_err;

    int n_chk  = 0;
    int n_fail = 0;

    dcache_burst_adapter #(.BEATS(4), .BEAT_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs set and outputs sampled 1ns after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp"},   256'(dfp_resp),   256'd0);
        check({tag, "_rdata"},  dfp_rdata,        256'd0);
        check({tag, "_baddr"},  256'(bmem_addr),  256'd0);
        check({tag, "_bread"},  256'(bmem_read),  256'd0);
        check({tag, "_bwrite"}, 256'(bmem_write), 256'd0);
        check({tag, "_bwdata"}, 256'(bmem_wdata), 256'd0);
        check({tag, "_perr"},   256'(proto_err),  256'd0);
    endtask

    logic [63:0]  wb  [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    logic [63:0]  wb2 [4] = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                              64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
    logic [63:0]  rb  [4] = '{64'h0000_0000_0000_000A, 64'h0000_0000_0000_000B,
                              64'h0000_0000_0000_000C, 64'h0000_0000_0000_000D};
    logic [63:0]  rb4 [4] = '{64'hCAFE_0000_0000_0000, 64'hCAFE_0000_0000_0001,
                              64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0003};
    logic [255:0] rline3 = {64'h0000_0000_0000_000D, 64'h0000_0000_0000_000C,
                            64'h0000_0000_0000_000B, 64'h0000_0000_0000_000A};
    logic [255:0] rline4 = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                            64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
    logic         pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b1; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        step;

        // ---- Write, ready always 1 ----
        dfp_addr  = 32'h0000_1234;
        dfp_wdata = {wb[3], wb[2], wb[1], wb[0]};
        dfp_write = 1'b1;
        check("w1_idle_quiet", 256'(bmem_write), 256'd0);
        for (int i = 0; i < 4; i++) begin
            step;
            if (i == 0) dfp_wdata = {256{1'b1}};   // late change must not leak
            check("w1_bwrite", 256'(bmem_write), 256'd1);
            check("w1_baddr",  256'(bmem_addr),  256'h1220);
            check("w1_bwdata", 256'(bmem_wdata), 256'(wb[i]));
            check("w1_noresp", 256'(dfp_resp),   256'd0);
        end
        step;
        check("w1_resp",        256'(dfp_resp),   256'd1);
        check("w1_resp_nowr",   256'(bmem_write), 256'd0);
        step;                                       // GUARD, request still held
        check("w1_guard_resp",  256'(dfp_resp),   256'd0);
        check("w1_guard_nowr",  256'(bmem_write), 256'd0);
        dfp_write = 1'b0;
        step;
        check("w1_idle_nowr",   256'(bmem_write), 256'd0);
        step;
        check("w1_no_reaccept", 256'(bmem_write), 256'd0);

        // ---- Write with backpressure ----
        dfp_addr  = 32'h0000_5000;
        dfp_wdata = {wb2[3], wb2[2], wb2[1], wb2[0]};
        dfp_write = 1'b1;
        step;
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            bmem_ready = pat[k];
            check("w2_bwrite", 256'(bmem_write), 256'd1);
            check("w2_bwdata", 256'(bmem_wdata), 256'(wb2[idx]));
            check("w2_noresp", 256'(dfp_resp),   256'd0);
            if (pat[k]) idx++;
            step;
        end
        bmem_ready = 1'b1;
        check("w2_resp",      256'(dfp_resp),   256'd1);
        check("w2_resp_nowr", 256'(bmem_write), 256'd0);
        step;
        dfp_write = 1'b0;
        step;

        // ---- Read with gaps, command backpressured one cycle ----
        dfp_addr = 32'h8000_0040;
        dfp_read = 1'b1;
        step;
        bmem_ready = 1'b0;
        check("r1_bread_hold", 256'(bmem_read), 256'd1);
        check("r1_baddr",      256'(bmem_addr), 256'h8000_0040);
        step;
        bmem_ready = 1'b1;
        check("r1_bread_hs",   256'(bmem_read), 256'd1);
        step;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 2; g++) begin
                check("r1_gap_bread", 256'(bmem_read), 256'd0);
                check("r1_gap_resp",  256'(dfp_resp),  256'd0);
                step;
            end
            bmem_rvalid = 1'b1;
            bmem_rdata  = rb[b];
            step;
            bmem_rvalid = 1'b0;
        end
        check("r1_resp",  256'(dfp_resp), 256'd1);
        check("r1_rdata", dfp_rdata,      rline3);
        step;
        dfp_read = 1'b0;
        check("r1_guard_resp", 256'(dfp_resp), 256'd0);
        step;
        step;
        check("r1_rdata_hold", dfp_rdata,       rline3);
        check("r1_perr",       256'(proto_err), 256'd0);

        // ---- Writeback then refill on the same line ----
        dfp_addr  = 32'h0000_2000;
        dfp_wdata = {wb[3], wb[2], wb[1], wb[0]};
        dfp_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            check("wr_bwrite", 256'(bmem_write), 256'd1);
            check("wr_bwdata", 256'(bmem_wdata), 256'(wb[i]));
        end
        step;
        check("wr_wresp", 256'(dfp_resp), 256'd1);
        step;
        dfp_write = 1'b0;
        dfp_read  = 1'b1;
        check("wr_guard_nowr", 256'(bmem_write), 256'd0);
        step;
        check("wr_idle_nowr", 256'(bmem_write), 256'd0);
        check("wr_idle_nord", 256'(bmem_read),  256'd0);
        step;
        check("wr_bread",  256'(bmem_read),  256'd1);
        check("wr_no_dup", 256'(bmem_write), 256'd0);
        check("wr_baddr",  256'(bmem_addr),  256'h2000);
        step;
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = rb4[b];
            check("wr_rd_nowr", 256'(bmem_write), 256'd0);
            step;
        end
        bmem_rvalid = 1'b0;
        check("wr_rresp", 256'(dfp_resp), 256'd1);
        check("wr_rdata", dfp_rdata,      rline4);
        step;
        dfp_read = 1'b0;
        step;

        // ---- Both requests high: write first, read after GUARD ----
        dfp_addr  = 32'h0000_3000;
        dfp_wdata = {wb2[3], wb2[2], wb2[1], wb2[0]};
        dfp_write = 1'b1;
        dfp_read  = 1'b1;
        step;
        check("both_wr_first", 256'(bmem_write), 256'd1);
        check("both_no_read",  256'(bmem_read),  256'd0);
        repeat (3) step;
        step;
        check("both_wresp",      256'(dfp_resp), 256'd1);
        check("both_rdata_kept", dfp_rdata,      rline4);
        step;
        dfp_write = 1'b0;
        check("both_guard_nord", 256'(bmem_read), 256'd0);
        step;
        check("both_idle_nord",  256'(bmem_read), 256'd0);
        step;
        check("both_bread",  256'(bmem_read),  256'd1);
        check("both_baddr",  256'(bmem_addr),  256'h3000);
        step;

        // ---- Reset during beat 2 of the read ----
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = rb[b];
            step;
        end
        bmem_rvalid = 1'b1;
        bmem_rdata  = rb[2];
        #2;
        rst = 1'b0;
        bmem_rvalid = 1'b0;
        dfp_read = 1'b0;
        #1;
        check_all_zero("midrst");
        step;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("midrst_noresp", 256'(dfp_resp), 256'd0);
            step;
        end
        check("midrst_perr", 256'(proto_err), 256'd0);
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'hDEAD;
        step;
        bmem_rvalid = 1'b0;
        check("stray_perr_set", 256'(proto_err), 256'd1);
        repeat (3) step;
        check("stray_perr_sticky", 256'(proto_err), 256'd1);
        rst = 1'b0;
        #1;
        check("stray_perr_clr", 256'(proto_err), 256'd0);
        step;
        rst = 1'b1;
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_burst_adapter.md
Name: dcache_burst_adapter

Overview:
- Memory-side adapter directly downstream of the data-cache miss/writeback stage. It consumes that stage's line-granular dfp_read/dfp_write requests (32-byte lines, 256-bit data).
- It converts each request into a 4-beat, 64-bit burst transaction on the burst memory bus.
- It returns the assembled read line with a single-cycle dfp_resp, and also acknowledges writebacks with dfp_resp.
- The upstream stage holds a request level-high until it sees dfp_resp, then switches writeback to refill. This block must therefore never double-accept a held request.

Parameters:
BEATS, 4, beats per line; only 4 is supported.
BEAT_W, 64, bits per beat; line width = BEATS*BEAT_W = 256.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
dfp_addr  input  32  line address; bits [4:0] are ignored and forced to 0 on the bus
dfp_read  input  1  line refill request, held until dfp_resp
dfp_write  input  1  line writeback request, held until dfp_resp
dfp_wdata  input  256  writeback line, valid while dfp_write=1
dfp_rdata  output  256  refilled line
dfp_resp  output  1  one-cycle completion pulse for read or write
bmem_addr  output  32  burst line address, bits [4:0]=0
bmem_read  output  1  burst read command
bmem_write  output  1  burst write beat valid
bmem_wdata  output  64  write beat data
bmem_ready  input  1  memory accepts command/beat this cycle
bmem_rdata  input  64  read beat data
bmem_rvalid  input  1  read beat valid
proto_err  output  1  sticky: bmem_rvalid seen outside RD_WAIT

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat counter=0.
  - All outputs 0, including dfp_rdata, bmem_addr and proto_err.
  - The line buffer is cleared.
- Reset mid-burst abandons the transaction: no dfp_resp, partial beats are discarded.
- IDLE, request arbitration:
  - dfp_write=1 wins over dfp_read when both are high.
  - On acceptance, latch {dfp_addr[31:5],5'b0} into the address register and dfp_wdata into the line buffer.
  - Next state: WR_BEAT (write) or RD_REQ (read).
  - No bus outputs are asserted in IDLE.
- WR_BEAT:
  - Drive bmem_write=1, bmem_addr=latched address, bmem_wdata=buffer[64*cnt +: 64].
  - cnt advances only in cycles with bmem_ready=1.
  - When cnt=3 and bmem_ready=1, go to RESP and reset cnt to 0.
  - Upstream changes to dfp_wdata after acceptance have no effect.
- RD_REQ:
  - Drive bmem_read=1 and bmem_addr until a cycle with bmem_ready=1, then go to RD_WAIT.
  - bmem_read is asserted for exactly the handshake cycles; it is deasserted in RD_WAIT.
- RD_WAIT:
  - Each bmem_rvalid=1 writes bmem_rdata into buffer[64*cnt +: 64] and increments cnt.
  - Beats arrive in ascending order.
  - Gaps (rvalid=0) are allowed, with no timeout.
  - On the 4th beat, go to RESP.
- RESP (exactly 1 cycle):
  - dfp_resp=1.
  - For a read, dfp_rdata is updated from the buffer and already valid in this cycle, i.e. it is the registered buffer with the beat-3 write forwarded.
  - dfp_rdata then holds its value until the next read completes; writes never change dfp_rdata.
  - Next state: GUARD.
- GUARD (exactly 1 cycle):
  - Requests are ignored, because upstream deasserts or switches its request one cycle after seeing dfp_resp.
  - Next state: IDLE.
- Latency with bmem_ready tied 1, request first seen in cycle T:
  - Write: beats at T+1..T+4, dfp_resp at T+5.
  - Read: bmem_read at T+1; with beats in cycles B0..B3, dfp_resp at B3+1.
- Simultaneous events: bmem_rvalid during RD_REQ's handshake cycle or in any non-RD_WAIT state is dropped and sets proto_err. proto_err is cleared only by reset.
- Width rules: the address low 5 bits are always 0 on bmem_addr. Beat i maps to line bits [64i+63:64i], i.e. little-endian beat order.
- Exactly one command per accepted request. A request that is still held after GUARD is accepted again as a new transaction; that is upstream's responsibility.

Test Plan:
- Write, ready always 1: dfp_write=1, dfp_addr=0x0000_1234, wdata beats 0..3 = 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x0000_1220; bmem_wdata beats 0x11..,0x22..,0x33..,0x44.. in cycles T+1..T+4; dfp_resp=1 only at T+5; no accept at T+6.
- Write with backpressure: bmem_ready pattern 1,0,0,1,1,0,1 -> each beat held across ready=0 cycles, 4 accepted beats in order; dfp_resp the cycle after the 4th accepted beat.
- Read with gaps: dfp_read=1, addr 0x8000_0040; beats 0xA..0xD delivered with 2-cycle gaps -> single bmem_read handshake; dfp_rdata={0xD,0xC,0xB,0xA} (beat 3 in MSBs) valid in the dfp_resp cycle; dfp_rdata unchanged afterwards.
- Writeback-then-refill: dfp_write held, then one cycle after dfp_resp switch to dfp_read on the same line -> exactly one write burst then one read burst; no duplicate write burst.
- Both dfp_read and dfp_write high in IDLE -> write burst first; read accepted only after GUARD.
- Reset at beat 2 of a read -> all outputs 0 immediately; no dfp_resp. A stray rvalid after reset while in IDLE sets proto_err=1, which stays 1 until the next reset.
